// File: rtl/svc_rv_ext_mul.sv
// Iterative RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU).
// Unsigned shift-add on operand magnitudes, retiring BITS_PER_CYCLE multiplier bits
// per cycle with a fixed latency of 32/BITS_PER_CYCLE cycles. The sign is applied
// at the output.
module svc_rv_ext_mul #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  op,
  output logic        busy,
  output logic [31:0] result
);

  localparam int unsigned Lat  = 32 / BITS_PER_CYCLE;
  localparam int unsigned CntW = 6;
`ifdef RISCV_FORMAL_ALTOPS
  localparam int unsigned LastCnt = 1;
`else
  localparam int unsigned LastCnt = Lat - 1;
`endif

  logic [63:0]     mcand_q, mcand_d;
  logic [31:0]     mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [1:0]      op_q, op_d;
  logic [63:0]     acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic        rs1_sgn, rs2_sgn;
  logic [31:0] mag1, mag2;
  logic        neg_in;
  logic [63:0] acc_step;
  logic [63:0] prod64;

  // op[2] selects the divider group and never reaches this unit.
  logic unused_op;
  assign unused_op = op[2];

  // Operand sign handling: magnitudes and product sign of the incoming request.
  always_comb begin
    rs1_sgn = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
    rs2_sgn = (op[1:0] == 2'b01);
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    mag1    = (rs1_sgn && rs1[31]) ? (~rs1 + 32'd1) : rs1;
    mag2    = (rs2_sgn && rs2[31]) ? (~rs2 + 32'd1) : rs2;
    neg_in  = (rs1_sgn & rs1[31]) ^ (rs2_sgn & rs2[31]);
  end

  // One iteration: add the partial products selected by the low multiplier bits.
  always_comb begin
    acc_step = acc_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) begin
        acc_step = acc_step + (mcand_q << i);
      end
    end
  end

  // Next-state: start (also aborts an in-flight op) or iterate while busy.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (en) begin
      mcand_d  = {32'd0, mag1};
      mplier_d = mag2;
      neg_d    = neg_in;
      op_d     = op[1:0];
      cnt_d    = '0;
      busy_d   = 1'b1;
`ifdef RISCV_FORMAL_ALTOPS
      acc_d    = {32'd0, rs1 + rs2};
`else
      acc_d    = '0;
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q + CntW'(1);
`ifndef RISCV_FORMAL_ALTOPS
      acc_d    = acc_step;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
`endif
      if (cnt_q == CntW'(LastCnt)) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // Output word selection; mid-operation this shows the partial accumulator.
  always_comb begin
    prod64 = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef RISCV_FORMAL_ALTOPS
    unique case (op_q)
      2'b00:   result = acc_q[31:0] ^ 32'h5876063e;
      2'b01:   result = acc_q[31:0] ^ 32'hf6583fb7;
      2'b10:   result = acc_q[31:0] ^ 32'hecfbe137;
      default: result = acc_q[31:0] ^ 32'h949ce5e8;
    endcase
`else
    result = (op_q == 2'b00) ? prod64[31:0] : prod64[63:32];
`endif
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_svc_rv_ext_mul.sv
// Bench for svc_rv_ext_mul: three instances (BITS_PER_CYCLE = 1, 2, 4) share one
// stimulus stream and are checked against a plain 64-bit arithmetic model.
module tb_svc_rv_ext_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] rs1, rs2;
  logic [2:0]  op;
  logic [2:0]  busy_w;
  logic [31:0] res_w [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    svc_rv_ext_mul #(
      .BITS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .rs1   (rs1),
      .rs2   (rs2),
      .op    (op),
      .busy  (busy_w[g]),
      .result(res_w[g])
    );
  end

  // Reference: sign/zero extend to 64 bits, multiply, pick the word.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] o);
    logic [63:0] ea, eb, p;
    ea = (o[1:0] == 2'b01 || o[1:0] == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure busy length per instance, then check the held result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                        input logic scr, input logic [31:0] exp, input string tag);
    int          cnt [3];
    logic [2:0]  done;
    foreach (cnt[d]) cnt[d] = 0;
    done = 3'b000;
    rs1 = a;
    rs2 = b;
    op  = o;
    en  = 1'b1;
    step();
    en  = 1'b0;
    for (int k = 0; k < 40 && done != 3'b111; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (!done[d]) begin
          if (busy_w[d]) cnt[d]++;
          else done[d] = 1'b1;
        end
      end
      if (done != 3'b111) begin
        if (scr) begin
          rs1 = $urandom;
          rs2 = $urandom;
          op  = 3'($urandom_range(7, 0));
        end
        step();
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s lat bpc%0d", tag, 1 << d), cnt[d], 32 >> d);
      check($sformatf("%s res bpc%0d", tag, 1 << d), res_w[d], exp);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  o;

    rst = 1'b1;
    en  = 1'b0;
    rs1 = '0;
    rs2 = '0;
    op  = '0;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset busy bpc%0d", 1 << d), {31'd0, busy_w[d]}, 32'd0);
      check($sformatf("reset res bpc%0d", 1 << d), res_w[d], 32'd0);
    end
    #3 rst = 1'b0;
    step();

    // Directed corner products.
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 1'b0, 32'hFFFFFFFE, "mulhu_ff");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 1'b0, 32'h00000001, "mul_ff");
    run_op(32'h80000000, 32'h80000000, 3'b001, 1'b0, 32'h40000000, "mulh_min");
    run_op(32'h80000000, 32'h80000000, 3'b000, 1'b0, 32'h00000000, "mul_min");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 1'b0, 32'hFFFFFFFF, "mulhsu_ff");
    run_op(32'hFFFFFFF9, 32'h00000003, 3'b001, 1'b0, 32'hFFFFFFFF, "mulh_m7x3");
    run_op(32'hFFFFFFF9, 32'h00000003, 3'b000, 1'b0, 32'hFFFFFFEB, "mul_m7x3");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0, 32'hFFFFFFFE, "mulhu_op2");

    // Operands scrambled every cycle while busy.
    run_op(32'h12345678, 32'h9ABCDEF0, 3'b001, 1'b1, ref_mul(32'h12345678, 32'h9ABCDEF0, 3'b001),
           "scramble");

    // Abort: second start five edges after the first.
    rs1 = 32'hDEADBEEF;
    rs2 = 32'hCAFEF00D;
    op  = 3'b011;
    en  = 1'b1;
    step();
    en  = 1'b0;
    repeat (4) step();
    run_op(32'd7, 32'd6, 3'b000, 1'b0, 32'h0000002A, "abort");

    // Reset in the middle of an operation, between clock edges.
    rs1 = 32'hFFFFFFFF;
    rs2 = 32'hFFFFFFFF;
    op  = 3'b011;
    en  = 1'b1;
    step();
    en  = 1'b0;
    repeat (9) step();
    check("pre-rst busy bpc1", {31'd0, busy_w[0]}, 32'd1);
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("async rst busy bpc%0d", 1 << d), {31'd0, busy_w[d]}, 32'd0);
      check($sformatf("async rst res bpc%0d", 1 << d), res_w[d], 32'd0);
    end
    en = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("en in rst bpc%0d", 1 << d), {31'd0, busy_w[d]}, 32'd0);
    end
    en = 1'b0;
    #3 rst = 1'b0;
    step();
    run_op(32'd2, 32'd3, 3'b011, 1'b0, 32'h00000000, "post_rst_mulhu");
    run_op(32'd2, 32'd3, 3'b000, 1'b0, 32'h00000006, "post_rst_mul");

    // Random operand/op pairs, alternating quiet and scrambled inputs.
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom;
      o = 3'($urandom_range(7, 0));
      if (i % 8 == 0) a = 32'h80000000;
      if (i % 8 == 1) b = 32'hFFFFFFFF;
      if (i % 8 == 2) a = 32'd0;
      run_op(a, b, o, 1'((i >> 1) & 1), ref_mul(a, b, o), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
